// File: rtl/io_access_ctrl.sv
// MMIO controller for board IO: LED/segment write registers, non-blocking LED/button reads,
// and a blocking switch read that stalls the CPU until a debounced confirm-button press.
module io_access_ctrl #(
  parameter logic [31:0] SEG_ADDR        = 32'hFFFF_FFF0,
  parameter logic [31:0] LED_ADDR        = 32'hFFFF_FC60,
  parameter logic [31:0] SW_ADDR         = 32'hFFFF_FC70,
  parameter logic [31:0] BTN_ADDR        = 32'hFFFF_FC74,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        io_hit_o,
  output logic        stall_o,
  input  logic [15:0] sw_in_i,
  input  logic        confirm_btn_i,
  output logic [15:0] led_out_o,
  output logic [31:0] seg_data_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic            btn_sync1_q, btn_sync2_q;
  logic [15:0]     sw_sync1_q, sw_sync2_q;
  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            db_prev_q;
  logic [15:0]     sw_latch_q, sw_latch_d;
  logic [15:0]     led_q, led_d;
  logic [31:0]     seg_q, seg_d;
  logic            press;
  logic            is_rd;
  logic            sw_req;
  logic            stall;

  assign press  = db_level_q & ~db_prev_q;
  // A simultaneous store wins over the load, so the load is not seen at all.
  assign is_rd  = mem_rd_i & ~mem_wr_i;
  assign sw_req = is_rd & (addr_i == SW_ADDR);

  assign io_hit_o = (mem_rd_i | mem_wr_i) &
                    ((addr_i == SEG_ADDR) | (addr_i == LED_ADDR) |
                     (addr_i == SW_ADDR)  | (addr_i == BTN_ADDR));

  // Held in reset, the state register is already IDLE; this also kills the IDLE-cycle stall.
  assign stall_o    = stall & rst;
  assign led_out_o  = led_q;
  assign seg_data_o = seg_q;

  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (btn_sync2_q != db_level_q) begin
      if (db_cnt_q == CntMax) begin
        db_level_d = btn_sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    if (mem_wr_i && addr_i == LED_ADDR) led_d = wdata_i[15:0];
    if (mem_wr_i && addr_i == SEG_ADDR) seg_d = wdata_i;
  end

  always_comb begin
    state_d    = state_q;
    sw_latch_d = sw_latch_q;
    stall      = 1'b0;
    rdata_o    = '0;
    unique case (state_q)
      StIdle: begin
        if (sw_req) begin
          stall   = 1'b1;
          state_d = StWait;
        end else if (is_rd && addr_i == LED_ADDR) begin
          rdata_o = {16'b0, led_q};
        end else if (is_rd && addr_i == BTN_ADDR) begin
          rdata_o = {31'b0, db_level_q};
        end
      end
      StWait: begin
        if (!sw_req) begin
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          if (press) begin
            sw_latch_d = sw_sync2_q;
            state_d    = StDone;
          end
        end
      end
      StDone: begin
        rdata_o = {16'b0, sw_latch_q};
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      btn_sync1_q <= 1'b0;
      btn_sync2_q <= 1'b0;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      db_prev_q   <= 1'b0;
      sw_latch_q  <= '0;
      led_q       <= '0;
      seg_q       <= '0;
    end else begin
      state_q     <= state_d;
      btn_sync1_q <= confirm_btn_i;
      btn_sync2_q <= btn_sync1_q;
      sw_sync1_q  <= sw_in_i;
      sw_sync2_q  <= sw_sync1_q;
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_level_q;
      sw_latch_q  <= sw_latch_d;
      led_q       <= led_d;
      seg_q       <= seg_d;
    end
  end

endmodule

// File: tb/tb_io_access_ctrl.sv
// Randomized scoreboard bench for io_access_ctrl: stimulus queues expected load data,
// a monitor pops it whenever a load completes (mem_rd high, stall low).
module tb_io_access_ctrl;

  localparam int unsigned Deb     = 4;
  localparam logic [31:0] SegAddr = 32'hFFFF_FFF0;
  localparam logic [31:0] LedAddr = 32'hFFFF_FC60;
  localparam logic [31:0] SwAddr  = 32'hFFFF_FC70;
  localparam logic [31:0] BtnAddr = 32'hFFFF_FC74;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        io_hit, stall;
  logic [15:0] sw_in = '0;
  logic        btn = 1'b0;
  logic [15:0] led_out;
  logic [31:0] seg_data;

  io_access_ctrl #(.DEBOUNCE_CYCLES(Deb)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_i     (mem_rd),
    .mem_wr_i     (mem_wr),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .io_hit_o     (io_hit),
    .stall_o      (stall),
    .sw_in_i      (sw_in),
    .confirm_btn_i(btn),
    .led_out_o    (led_out),
    .seg_data_o   (seg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] led_m = '0;
  logic [31:0] seg_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: every completed load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && mem_rd && !mem_wr && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: actual rdata %h required no completion", rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("load_rdata", rdata, e.data);
        check("load_io_hit", {31'b0, io_hit}, {31'b0, e.hit});
      end
    end
  end

  function automatic logic is_io(input logic [31:0] a);
    return (a == SegAddr) || (a == LedAddr) || (a == SwAddr) || (a == BtnAddr);
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mem_wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    check("store_io_hit", {31'b0, io_hit}, {31'b0, is_io(a)});
    @(posedge clk); #1;
    mem_wr = 1'b0;
    if (a == LedAddr) led_m = d[15:0];
    if (a == SegAddr) seg_m = d;
    @(negedge clk);
    check("led_out", {16'b0, led_out}, {16'b0, led_m});
    check("seg_data", seg_data, seg_m);
  endtask

  task automatic nb_load(input logic [31:0] a, input logic [31:0] d, input logic hit);
    @(posedge clk); #1;
    mem_rd = 1'b1; addr = a;
    exp_q.push_back('{data: d, hit: hit});
    @(posedge clk); #1;
    mem_rd = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sw_start(input logic [15:0] sw);
    sw_in = sw;
    cycles(3);
    mem_rd = 1'b1; addr = SwAddr;
    @(negedge clk);
    check("stall_first_cycle", {31'b0, stall}, 32'd1);
  endtask

  // Bouncy press that ends held high.
  task automatic bounce_press();
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(1);
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(1);
    btn = 1'b1;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL blocking_read_timeout: actual stall 1 required completion within 40 cycles");
    end
    @(posedge clk); #1;
    mem_rd = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic [31:0] a, d;
    int unsigned op;

    cycles(3);
    @(negedge clk);
    check("reset_led", {16'b0, led_out}, 32'd0);
    check("reset_seg", seg_data, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    rst = 1'b1;

    store(LedAddr, 32'h1234_ABCD);
    nb_load(LedAddr, 32'h0000_ABCD, 1'b1);
    store(SegAddr, 32'hDEAD_BEEF);
    store(32'hFFFF_FC00, 32'h5555_AAAA);
    nb_load(BtnAddr, 32'd0, 1'b1);

    // Load and store together: store wins, no stall.
    @(posedge clk); #1;
    mem_rd = 1'b1; mem_wr = 1'b1; addr = SwAddr; wdata = 32'h0;
    @(negedge clk);
    check("rdwr_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      d  = $urandom;
      a  = $urandom & 32'h7FFF_FFFC;
      case (op)
        0: store(LedAddr, d);
        1: store(SegAddr, d);
        2: store(a, d);
        3: nb_load(LedAddr, {16'b0, led_m}, 1'b1);
        4: nb_load(BtnAddr, 32'd0, 1'b1);
        default: nb_load(a, 32'd0, 1'b0);
      endcase
    end

    // Blocking read with a bouncy press.
    sw_start(16'h00A5);
    cycles(2);
    @(negedge clk);
    check("stall_wait", {31'b0, stall}, 32'd1);
    exp_q.push_back('{data: 32'h0000_00A5, hit: 1'b1});
    bounce_press();
    wait_done();
    nb_load(BtnAddr, 32'd1, 1'b1);

    // Held button must not satisfy a new read.
    s = 16'($urandom);
    sw_start(s);
    cycles(15);
    @(negedge clk);
    check("held_btn_stall", {31'b0, stall}, 32'd1);
    btn = 1'b0;
    cycles(Deb + 6);
    exp_q.push_back('{data: {16'b0, s}, hit: 1'b1});
    btn = 1'b1;
    wait_done();
    btn = 1'b0;
    cycles(Deb + 6);

    // Glitch shorter than the debounce window, then flush.
    sw_start(16'($urandom));
    btn = 1'b1; cycles(2);
    btn = 1'b0; cycles(12);
    @(negedge clk);
    check("glitch_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    mem_rd = 1'b0;
    @(negedge clk);
    check("flush_stall", {31'b0, stall}, 32'd0);
    // Press while idle is discarded.
    btn = 1'b1; cycles(Deb + 6);
    btn = 1'b0; cycles(Deb + 6);
    s = 16'($urandom);
    sw_start(s);
    cycles(10);
    @(negedge clk);
    check("no_queued_press", {31'b0, stall}, 32'd1);
    exp_q.push_back('{data: {16'b0, s}, hit: 1'b1});
    bounce_press();
    wait_done();
    btn = 1'b0;
    cycles(Deb + 6);

    // Asynchronous reset while waiting.
    store(LedAddr, 32'h0000_5A5A);
    store(SegAddr, 32'hCAFE_F00D);
    sw_start(16'h1234);
    cycles(2);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_stall", {31'b0, stall}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_led", {16'b0, led_out}, 32'd0);
    check("async_rst_seg", seg_data, 32'd0);
    mem_rd = 1'b0;
    led_m = '0;
    seg_m = '0;
    cycles(2);
    rst = 1'b1;
    nb_load(LedAddr, 32'd0, 1'b1);
    cycles(3);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
